// File: rtl/fifo_ram_stat.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty flags,
// one-cycle overflow/underflow pulses and a registered or fall-through read port.
module fifo_ram_stat #(
    parameter int BWIDTH    = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = 14,
    parameter int AE_THRESH = 2,
    parameter int FWFT      = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       w_en,
    input  logic [BWIDTH-1:0]          w_data,
    input  logic                       r_en,
    output logic [BWIDTH-1:0]          r_data,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
    localparam logic [PW-1:0] AF_C    = PW'(AF_THRESH);
    localparam logic [PW-1:0] AE_C    = PW'(AE_THRESH);

    // Handshake: w_en is the write valid and !full its ready; r_en is the read
    // valid and !empty its ready. A transfer happens only at a rising edge where
    // both halves of the pair are high; otherwise nothing in the FIFO moves.

    logic [PW-1:0]     wptr_q, wptr_d;
    logic [PW-1:0]     rptr_q, rptr_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic [BWIDTH-1:0] mem_q [DEPTH];

    logic [PW-1:0]     count_w;
    logic [AW-1:0]     waddr;
    logic [AW-1:0]     raddr;
    logic              w_acc;
    logic              r_acc;

    // Flags decode from registered pointers only, so they never see w_en/r_en.
    always_comb begin
        count_w      = wptr_q - rptr_q;
        full         = (count_w == DEPTH_C);
        empty        = (count_w == '0);
        almost_full  = (count_w >= AF_C);
        almost_empty = (count_w <= AE_C);
        waddr        = wptr_q[AW-1:0];
        raddr        = rptr_q[AW-1:0];
    end

    always_comb begin
        w_acc       = w_en && !full;
        r_acc       = r_en && !empty;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        overflow_d  = w_en && full;
        underflow_d = r_en && empty;
        if (w_acc) begin
            wptr_d = wptr_q + PW'(1);
        end
        if (r_acc) begin
            rptr_d = rptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately not cleared by reset; the pointers make it unreachable.
    always_ff @(posedge clk) begin
        if (!rst && w_acc) begin
            mem_q[waddr] <= w_data;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is presented directly; meaningful only while !empty.
            assign r_data = mem_q[raddr];
        end else begin : g_std
            logic [BWIDTH-1:0] rdata_q, rdata_d;

            always_comb begin
                rdata_d = rdata_q;
                if (r_acc) begin
                    rdata_d = mem_q[raddr];
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    rdata_q <= '0;
                end else begin
                    rdata_q <= rdata_d;
                end
            end

            assign r_data = rdata_q;
        end
    endgenerate

    assign count     = count_w;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule
